// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Keeps the PC, fetches 32-bit words from instruction memory with at most
//   one request outstanding, and buffers them in an in-order queue whose head
//   is presented to decode.
//   The unit accepts PC redirects, which flush wrong-path words. Decode
//   back-pressure (stall) holds the head word. Fetch is throttled by the
//   free space (credit) left in the queue.
// Ports
//   clk, reset            clock; synchronous active-high reset
//   imem_req, imem_addr   one-cycle fetch request and its word-aligned address
//   imem_valid, imem_rdata
//                         memory response strobe and instruction word
//   redirect_valid, redirect_pc
//                         one-cycle redirect strobe and new PC (bits [1:0] dropped)
//   stall                 decode not ready; the head word is held
//   inst_valid            queue non-empty
//   instruction, opCode, functCode, pc_out, pc_plus4
//                         head word, its fields, its address and address + 4
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [5:0]  opCode,
    output logic [5:0]  functCode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [31:0]   q_data [QUEUE_DEPTH];
    logic [31:0]   q_pc   [QUEUE_DEPTH];
    logic [31:0]   last_data, last_pc;
    logic [31:0]   redir_pc;
    logic          issue, push, pop;

    // Masking keeps every redirect_pc bit in use while forcing word alignment.
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && !stall;
    assign push       = (state == S_WAIT) && imem_valid && !redirect_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (issue) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_valid)          state_nxt = S_IDLE;
                else if (redirect_valid) state_nxt = S_FLUSH;
            end
            S_FLUSH: if (imem_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: a request lives for the single IDLE cycle before WAIT.
    always_comb begin
        issue     = (state == S_IDLE) && !redirect_valid && (count < CW'(QUEUE_DEPTH));
        imem_req  = issue && !reset;
        imem_addr = fetch_pc;
    end

    // PC, queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            last_data   <= '0;
            last_pc     <= '0;
        end else begin
            if (inst_valid) begin
                last_data <= q_data[head];
                last_pc   <= q_pc[head];
            end
            if (redirect_valid) begin
                fetch_pc <= redir_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    fetch_pc    <= fetch_pc + 32'd4;
                    inflight_pc <= fetch_pc;
                end
                if (push) tail <= (tail == PW'(QUEUE_DEPTH - 1)) ? '0 : tail + 1'b1;
                if (pop)  head <= (head == PW'(QUEUE_DEPTH - 1)) ? '0 : head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    // Queue storage; contents are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_data[tail] <= imem_rdata;
            q_pc[tail]   <= inflight_pc;
        end
    end

    // When empty, the outputs hold the last head that was presented.
    assign instruction = inst_valid ? q_data[head] : last_data;
    assign pc_out      = inst_valid ? q_pc[head]   : last_pc;
    assign pc_plus4    = pc_out + 32'd4;
    assign opCode      = instruction[31:26];
    assign functCode   = instruction[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [5:0]  opCode;
    logic [5:0]  functCode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .inst_valid(inst_valid),
        .instruction(instruction), .opCode(opCode), .functCode(functCode),
        .pc_out(pc_out), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},   32'd0);
        chk({tag, "_addr"},  imem_addr,           32'h0);
        chk({tag, "_ivld"},  {31'd0, inst_valid}, 32'd0);
        chk({tag, "_instr"}, instruction,         32'h0);
        chk({tag, "_pc"},    pc_out,              32'h0);
        chk({tag, "_pc4"},   pc_plus4,            32'h4);
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
        tick();
        tick();
        #1;
        chk_reset_vals("rst0");

        // Basic fetch, memory latency 1
        reset = 1'b0; #1;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        tick();
        chk("t1_req_wait", {31'd0, imem_req}, 32'd0);
        imem_valid = 1'b1; imem_rdata = 32'h8C01_0004; #1;
        chk("t1_ivld_pre", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_valid = 1'b0; #1;
        chk("t2_ivld0", {31'd0, inst_valid}, 32'd1);
        chk("t2_op0", {26'd0, opCode}, 32'h23);
        chk("t2_pc0", pc_out, 32'h0);
        chk("t2_pc4_0", pc_plus4, 32'h4);
        chk("t2_req1", {31'd0, imem_req}, 32'd1);
        chk("t2_addr1", imem_addr, 32'h4);
        tick();
        chk("t2_empty", {31'd0, inst_valid}, 32'd0);
        chk("t2_hold", instruction, 32'h8C01_0004);
        imem_valid = 1'b1; imem_rdata = 32'h0022_1820;
        tick();
        imem_valid = 1'b0; #1;
        chk("t2_ivld1", {31'd0, inst_valid}, 32'd1);
        chk("t2_op1", {26'd0, opCode}, 32'h00);
        chk("t2_fn1", {26'd0, functCode}, 32'h20);
        chk("t2_pc1", pc_out, 32'h4);
        chk("t2_pc4_1", pc_plus4, 32'h8);

        // Stall fills the queue, then fetch resumes
        do_reset();
        stall = 1'b1;
        chk("t3_req0", imem_addr, 32'h0);
        tick();
        imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_valid = 1'b0; #1;
        chk("t3_req1", {31'd0, imem_req}, 32'd1);
        chk("t3_addr1", imem_addr, 32'h4);
        tick();
        imem_valid = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        imem_valid = 1'b0; #1;
        chk("t3_full_req", {31'd0, imem_req}, 32'd0);
        chk("t3_head_pc", pc_out, 32'h0);
        tick();
        chk("t3_full_req2", {31'd0, imem_req}, 32'd0);
        chk("t3_head_instr", instruction, 32'h1111_1111);
        stall = 1'b0;
        tick();
        chk("t3_pop_pc", pc_out, 32'h4);
        chk("t3_pop_instr", instruction, 32'h2222_2222);
        chk("t3_resume_req", {31'd0, imem_req}, 32'd1);
        chk("t3_resume_addr", imem_addr, 32'h8);
        tick();

        // Redirect while the request to 0x8 is outstanding
        chk("t4_empty", {31'd0, inst_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("t4_req_wait", {31'd0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0; #1;
        chk("t4_dropped", {31'd0, inst_valid}, 32'd0);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h40);
        tick();
        imem_valid = 1'b1; imem_rdata = 32'h3333_3333;
        tick();
        imem_valid = 1'b0; #1;
        chk("t4_pc", pc_out, 32'h40);
        chk("t4_instr", instruction, 32'h3333_3333);
        tick();

        // Redirect in the same cycle as the response
        imem_valid = 1'b1; imem_rdata = 32'h4444_4444;
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        imem_valid = 1'b0; redirect_valid = 1'b0; #1;
        chk("t5_dropped", {31'd0, inst_valid}, 32'd0);
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        chk("t5_addr", imem_addr, 32'h100);
        tick();

        // Reset with a request in flight and a word queued
        stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        imem_valid = 1'b0; #1;
        chk("t6_pc", pc_out, 32'h100);
        chk("t6_addr", imem_addr, 32'h104);
        tick();
        reset = 1'b1; #1;
        chk("t6_req_rst", {31'd0, imem_req}, 32'd0);
        tick();
        imem_valid = 1'b1; imem_rdata = 32'h6666_6666; #1;
        chk_reset_vals("t6_rst");
        tick();
        reset = 1'b0; imem_valid = 1'b0; stall = 1'b0; #1;
        chk("t6_ivld", {31'd0, inst_valid}, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr0", imem_addr, 32'h0);
        tick();
        chk("t6_late_ignored", {31'd0, inst_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
